// File: rtl/ext_shift_seq.sv
// Operand extension (zero/sign/upper/pass) followed by a STEP-bits-per-cycle shifter.
// start is accepted in IDLE or DONE; done pulses once when result is updated.
module ext_shift_seq #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [1:0]         ext_op,
    input  logic [IN_W-1:0]    imm_in,
    input  logic [OUT_W-1:0]   data_in,
    input  logic [1:0]         shift_op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   result
);

    if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_in_w
        $error("ext_shift_seq: IN_W must be in 1..OUT_W-1");
    end
    if (OUT_W < 4 || (OUT_W & (OUT_W - 1)) != 0) begin : g_bad_out_w
        $error("ext_shift_seq: OUT_W must be a power of 2 and >= 4");
    end
    if (STEP < 1 || STEP > OUT_W / 2 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $error("ext_shift_seq: STEP must be a power of 2 in 1..OUT_W/2");
    end
    if (SHAMT_W != $clog2(OUT_W)) begin : g_bad_shamt_w
        $error("ext_shift_seq: SHAMT_W must equal clog2(OUT_W)");
    end

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         sop_q, sop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   result_q, result_d;

    logic [OUT_W-1:0]   ext_val;
    logic [SHAMT_W-1:0] step_k;
    logic [OUT_W-1:0]   shifted;

    always_comb begin
        ext_val = '0;
        unique case (ext_op)
            2'b00:   ext_val = {{(OUT_W-IN_W){1'b0}}, imm_in};
            2'b01:   ext_val = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
            2'b10:   ext_val = {imm_in, {(OUT_W-IN_W){1'b0}}};
            default: ext_val = data_in;
        endcase
    end

    // The final partial step shifts only what remains of the count.
    always_comb begin
        step_k  = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        shifted = acc_q;
        unique case (sop_q)
            2'b01:   shifted = acc_q << step_k;
            2'b10:   shifted = acc_q >> step_k;
            2'b11:   shifted = $signed(acc_q) >>> step_k;
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sop_d    = sop_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_d   = ext_val;
                    cnt_d   = (shift_op == 2'b00) ? '0 : shamt;
                    sop_d   = shift_op;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = shifted;
                    cnt_d = cnt_q - step_k;
                end else begin
                    result_d = acc_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sop_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
